// File: rtl/multi_cycle_control_if.sv
// multi_cycle_control_if: control bus between the multi-cycle MIPS controller and its datapath/memory.
//   opcode, mem_ready          : datapath/memory -> controller
//   PCWrite..PCSource          : controller -> datapath strobes and selects
//   state, instr_done,
//   illegal_op, bus_err        : controller status (debug, retire pulse, traps)
//   master = controller side, slave = datapath/memory side.
interface multi_cycle_control_if #(
    parameter int ALUOP_W = 3
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               PCWrite;
    logic               BranchEQ;
    logic               BranchNE;
    logic               BranchGTZ;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemToReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic [1:0]         PCSource;
    logic [3:0]         state;
    logic               instr_done;
    logic               illegal_op;
    logic               bus_err;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, BranchEQ, BranchNE, BranchGTZ, IorD, MemRead, MemWrite,
               IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state, instr_done, illegal_op, bus_err
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, BranchEQ, BranchNE, BranchGTZ, IorD, MemRead, MemWrite,
               IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state, instr_done, illegal_op, bus_err
    );
endinterface

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle MIPS control FSM with memory wait states, bus timeout and illegal-opcode trap.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, forces FETCH
//   bus   : multi_cycle_control_if.master (opcode/mem_ready in; datapath strobes, state and status pulses out)
module multi_cycle_control #(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multi_cycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_GTZ   = ALUOP_W'(3);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t        cur, nxt;
    logic [CW-1:0] cnt;
    logic [5:0]    op_q;
    logic          waiting;
    logic          timeout;

    // cnt holds the number of earlier consecutive stalled cycles, so the
    // MEM_TIMEOUT-th stalled cycle is the one that raises bus_err.
    assign waiting = (cur == FETCH || cur == MEM_RD || cur == MEM_WR) && !bus.mem_ready;
    assign timeout = (MEM_TIMEOUT != 0) && waiting && (32'(cnt) == MEM_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= FETCH;
            cnt  <= '0;
            op_q <= '0;
        end else begin
            cur  <= nxt;
            cnt  <= (MEM_TIMEOUT != 0 && waiting && !timeout) ? cnt + CW'(1) : '0;
            op_q <= (cur == DECODE) ? bus.opcode : op_q;
        end
    end

    always_comb begin
        nxt            = cur;
        bus.PCWrite    = 1'b0;
        bus.BranchEQ   = 1'b0;
        bus.BranchNE   = 1'b0;
        bus.BranchGTZ  = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemToReg   = 1'b0;
        bus.RegDst     = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUOp      = ALU_ADD;
        bus.PCSource   = 2'b00;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;
        case (cur)
            FETCH: begin
                bus.MemRead = !timeout;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                nxt         = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target PC+4+(imm<<2) is precomputed here for BRANCH.
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    OP_R:                      nxt = EXEC;
                    OP_LW, OP_SW:              nxt = MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BGTZ:   nxt = BRANCH;
                    OP_J:                      nxt = JUMP;
                    OP_ADDI:                   nxt = ADDI_EX;
                    default: begin
                        bus.illegal_op = 1'b1;
                        nxt            = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                nxt         = (op_q == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                bus.MemRead = !timeout;
                bus.IorD    = 1'b1;
                nxt         = bus.mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                bus.MemToReg   = 1'b1;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                nxt            = FETCH;
            end
            MEM_WR: begin
                bus.MemWrite   = !timeout;
                bus.IorD       = 1'b1;
                bus.instr_done = bus.mem_ready;
                nxt            = bus.mem_ready ? FETCH : MEM_WR;
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_FUNCT;
                nxt         = R_WB;
            end
            R_WB: begin
                bus.RegDst     = 1'b1;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                nxt            = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.PCSource   = 2'b01;
                bus.ALUOp      = (op_q == OP_BGTZ) ? ALU_GTZ : ALU_SUB;
                bus.BranchEQ   = (op_q == OP_BEQ);
                bus.BranchNE   = (op_q == OP_BNE);
                bus.BranchGTZ  = (op_q == OP_BGTZ);
                bus.instr_done = 1'b1;
                nxt            = FETCH;
            end
            JUMP: begin
                bus.PCWrite    = 1'b1;
                bus.PCSource   = 2'b10;
                bus.instr_done = 1'b1;
                nxt            = FETCH;
            end
            ADDI_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                nxt         = ADDI_WB;
            end
            ADDI_WB: begin
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                nxt            = FETCH;
            end
            default: nxt = FETCH;
        endcase
        // A timed-out access abandons the instruction; mem_ready in that
        // same cycle already took the normal path since timeout needs it low.
        if (timeout) nxt = FETCH;
    end

    assign bus.state   = cur;
    assign bus.bus_err = timeout;
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: randomized instruction stream against a timeline model of the multi-cycle controller.
//   Builds the expected per-cycle state/strobe sequence of each instruction from its opcode and wait counts,
//   plus directed boundary cases (timeout edge, async reset in MEM_WB, disabled timeout).
module tb_multi_cycle_control;
    localparam int T = 15;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic       berr;
    } ent_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    ent_t q[$];
    logic [5:0] cur_op;

    multi_cycle_control_if #(.ALUOP_W(3)) bus ();
    multi_cycle_control_if #(.ALUOP_W(3)) b0 ();

    multi_cycle_control #(.ALUOP_W(3), .MEM_TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    multi_cycle_control #(.ALUOP_W(3), .MEM_TIMEOUT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h07, 6'h02, 6'h08};
    endfunction

    // Expected strobe vector for one cycle, from the per-state output table.
    function automatic logic [21:0] expv(input logic [3:0] s, input logic [5:0] op, input logic m, input logic b);
        logic pcw = 0, beq = 0, bne = 0, bgtz = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rdst = 0, rw = 0, asa = 0, done = 0, ill = 0;
        logic [1:0] asb = 0, pcs = 0;
        logic [2:0] aop = 0;
        case (s)
            4'd0:  begin mrd = !b; asb = 2'b01; irw = m; pcw = m; end
            4'd1:  begin asb = 2'b11; ill = !legal(op); end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = !b; iord = 1; end
            4'd4:  begin m2r = 1; rw = 1; done = 1; end
            4'd5:  begin mwr = !b; iord = 1; done = m; end
            4'd6:  begin asa = 1; aop = 3'd2; end
            4'd7:  begin rdst = 1; rw = 1; done = 1; end
            4'd8:  begin
                asa = 1; pcs = 2'b01; done = 1;
                aop = (op == 6'h07) ? 3'd3 : 3'd1;
                beq = (op == 6'h04); bne = (op == 6'h05); bgtz = (op == 6'h07);
            end
            4'd9:  begin pcw = 1; pcs = 2'b10; done = 1; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, beq, bne, bgtz, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, done, ill, b};
    endfunction

    function automatic logic [21:0] obsv();
        return {bus.PCWrite, bus.BranchEQ, bus.BranchNE, bus.BranchGTZ, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.PCSource, bus.instr_done, bus.illegal_op, bus.bus_err};
    endfunction

    // Pushes w stalled cycles then a ready cycle in state s; a stall of T or
    // more ends in a bus_err cycle instead. Returns ok=0 when aborted.
    task automatic waits(input logic [3:0] s, input int w, output bit ok);
        int n = (w >= T) ? T : w;
        for (int i = 0; i < n; i++) q.push_back('{s, 1'b0, (w >= T) && (i == T - 1)});
        ok = (w < T);
        if (ok) q.push_back('{s, 1'b1, 1'b0});
    endtask

    task automatic build(input logic [5:0] op, input int fw, input int mw);
        bit ok;
        waits(4'd0, fw, ok);
        if (!ok) return;
        q.push_back('{4'd1, 1'($urandom), 1'b0});
        case (op)
            6'h00: begin q.push_back('{4'd6, 1'($urandom), 1'b0}); q.push_back('{4'd7, 1'($urandom), 1'b0}); end
            6'h23: begin
                q.push_back('{4'd2, 1'($urandom), 1'b0});
                waits(4'd3, mw, ok);
                if (ok) q.push_back('{4'd4, 1'($urandom), 1'b0});
            end
            6'h2B: begin q.push_back('{4'd2, 1'($urandom), 1'b0}); waits(4'd5, mw, ok); end
            6'h04, 6'h05, 6'h07: q.push_back('{4'd8, 1'($urandom), 1'b0});
            6'h02: q.push_back('{4'd9, 1'($urandom), 1'b0});
            6'h08: begin q.push_back('{4'd10, 1'($urandom), 1'b0}); q.push_back('{4'd11, 1'($urandom), 1'b0}); end
            default: ;
        endcase
    endtask

    task automatic check_cycle(input ent_t e);
        logic [21:0] ev;
        ev = expv(e.st, cur_op, e.mr, e.berr);
        tests++;
        assert (bus.state === e.st) else begin
            fails++;
            $error("FAIL state op=%h got=%0d exp=%0d", cur_op, bus.state, e.st);
        end
        tests++;
        assert (obsv() === ev) else begin
            fails++;
            $error("FAIL strobes op=%h st=%0d got=%h exp=%h", cur_op, e.st, obsv(), ev);
        end
    endtask

    task automatic run_q(input int keep);
        ent_t e;
        while (q.size() > keep) begin
            e = q.pop_front();
            bus.mem_ready = e.mr;
            @(negedge clk);
            check_cycle(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic instr(input logic [5:0] op, input int fw, input int mw);
        cur_op     = op;
        bus.opcode = op;
        build(op, fw, mw);
        run_q(0);
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 1, T + 2)) : int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [5:0] lg [8];
        logic [5:0] op;
        ent_t e;
        lg = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h07, 6'h02, 6'h08};
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.opcode = 6'h00;
        bus.mem_ready = 1'b0;
        b0.opcode = 6'h00;
        b0.mem_ready = 1'b0;
        cur_op = 6'h00;
        repeat (3) @(negedge clk);
        check_cycle('{4'd0, 1'b0, 1'b0});
        @(posedge clk);
        #1 rst_n = 1'b1;

        instr(6'h00, 0, 0);
        instr(6'h3F, 0, 0);
        instr(6'h04, 0, 0);
        instr(6'h05, 0, 0);
        instr(6'h07, 0, 0);
        instr(6'h02, 0, 0);
        instr(6'h08, 0, 0);
        instr(6'h23, 0, 2);
        instr(6'h2B, 0, 0);
        instr(6'h2B, 0, 99);
        instr(6'h2B, 0, T - 1);
        instr(6'h23, 0, T);
        instr(6'h23, 1, T - 1);
        instr(6'h00, T, 0);
        instr(6'h00, T - 1, 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                while (legal(op)) op = 6'($urandom);
            end else begin
                op = lg[$urandom_range(0, 7)];
            end
            instr(op, rand_wait(), rand_wait());
        end

        // lw with two stalls, reset pulled asynchronously in MEM_WB.
        cur_op = 6'h23;
        bus.opcode = 6'h23;
        build(6'h23, 0, 2);
        run_q(1);
        e = q.pop_front();
        bus.mem_ready = e.mr;
        @(negedge clk);
        check_cycle(e);
        #1 rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        tests++;
        assert (bus.state === 4'd0 && bus.RegWrite === 1'b0) else begin
            fails++;
            $error("FAIL async_reset got state=%0d RegWrite=%b exp state=0 RegWrite=0", bus.state, bus.RegWrite);
        end
        check_cycle('{4'd0, 1'b0, 1'b0});
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Timeout disabled: sw stalled in MEM_WR for over 100 cycles.
        b0.opcode = 6'h2B;
        b0.mem_ready = 1'b1;
        @(posedge clk);
        #1 b0.mem_ready = 1'b0;
        for (int i = 0; i < 105; i++) begin
            @(negedge clk);
            tests++;
            assert (b0.bus_err === 1'b0) else begin
                fails++;
                $error("FAIL no_timeout cycle=%0d bus_err=%b exp=0", i, b0.bus_err);
            end
        end
        tests++;
        assert (b0.state === 4'd5 && b0.MemWrite === 1'b1) else begin
            fails++;
            $error("FAIL no_timeout_hold got state=%0d MemWrite=%b exp state=5 MemWrite=1", b0.state, b0.MemWrite);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
